// File: rtl/mem_wb_if.sv
// ============================================================================
// Module      : mem_wb_if
// Description : Bundles the MEM/WB stage's EX/MEM inputs, data-memory port,
//               register-file write port and status signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_wb_if;
  // EX/MEM pipeline inputs
  logic        mem_r_en;
  logic        mem_w_en;
  logic        wb_en;
  logic [3:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] val_rm;
  // Upstream hold
  logic        freeze;
  // Data-memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  // Register-file write port and status
  logic        writeBackEn;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;
  logic        addr_err;

  // Environment side: pipeline and memory model
  modport master (
    output mem_r_en, mem_w_en, wb_en, dest, alu_result, val_rm,
    output mem_rdata, mem_ack,
    input  freeze, mem_req, mem_we, mem_addr, mem_wdata,
    input  writeBackEn, Dest_wb, Result_WB, addr_err
  );

  // Stage side
  modport slave (
    input  mem_r_en, mem_w_en, wb_en, dest, alu_result, val_rm,
    input  mem_rdata, mem_ack,
    output freeze, mem_req, mem_we, mem_addr, mem_wdata,
    output writeBackEn, Dest_wb, Result_WB, addr_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : Combined MEM/WB pipeline stage. Issues load/store requests to
//               a handshaked data memory, freezes upstream while an access is
//               outstanding, aborts on timeout, and drives the register-file
//               write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  wire logic clk,
  input  wire logic rst,
  mem_wb_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  state_t      state_q;
  logic [7:0]  timer_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] load_data_q;
  logic        addr_err_q;

  logic        wb_en_q;
  logic [3:0]  dest_q;
  logic [31:0] result_q;

  logic        mem_op;
  logic        in_range;
  logic        freeze;
  logic        is_load;
  logic [31:0] mem_addr_d;
  logic [7:0]  timer_d;
  logic [31:0] result_d;

  assign mem_op   = bus.mem_r_en | bus.mem_w_en;
  assign in_range = (bus.alu_result >= BASE_ADDR);
  // A store wins when both enables are set, so only a pure load returns data.
  assign is_load  = bus.mem_r_en & ~bus.mem_w_en;
  // Word index: byte-offset bits of the address are dropped before rebasing.
  assign mem_addr_d = {2'b00, bus.alu_result[31:2] - BASE_ADDR[31:2]};
  assign timer_d    = timer_q + 8'd1;
  assign result_d   = is_load ? load_data_q : bus.alu_result;

  // Hold upstream from the moment a memory op is seen until the access ends;
  // forced low during reset so the pipeline is not stalled by stale inputs.
  assign freeze = rst & (((state_q == S_IDLE) & mem_op) | (state_q == S_BUSY));

  // Access sequencer: issues the request, waits for ack or timeout, then
  // spends one DONE cycle so the write-back register can capture the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      timer_q     <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      load_data_q <= 32'd0;
      addr_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            if (in_range) begin
              state_q     <= S_BUSY;
              timer_q     <= 8'd0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.mem_w_en;
              mem_addr_q  <= mem_addr_d;
              mem_wdata_q <= bus.val_rm;
            end else begin
              // Below the memory window: no access, flag it, load reads as 0.
              state_q     <= S_DONE;
              addr_err_q  <= 1'b1;
              load_data_q <= 32'd0;
            end
          end
        end
        S_BUSY: begin
          if (bus.mem_ack) begin
            state_q     <= S_DONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            load_data_q <= bus.mem_rdata;
          end else if (timer_d == TIMEOUT) begin
            state_q     <= S_DONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            load_data_q <= ABORT_DATA;
            addr_err_q  <= 1'b1;
            timer_q     <= timer_d;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Write-back register: advance when not frozen, otherwise insert a bubble
  // and keep the previous destination/result visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q  <= 1'b0;
      dest_q   <= 4'd0;
      result_q <= 32'd0;
    end else if (!freeze) begin
      wb_en_q  <= bus.wb_en;
      dest_q   <= bus.dest;
      result_q <= result_d;
    end else begin
      wb_en_q  <= 1'b0;
    end
  end

  assign bus.freeze      = freeze;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.writeBackEn = wb_en_q;
  assign bus.Dest_wb     = dest_q;
  assign bus.Result_WB   = result_q;
  assign bus.addr_err    = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Directed self-checking bench for mem_wb_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mem_wb_if bus ();

  mem_wb_stage #(
    .BASE_ADDR(32'd1024),
    .TIMEOUT  (8'd255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    bus.mem_r_en   = 1'b0;
    bus.mem_w_en   = 1'b0;
    bus.wb_en      = 1'b0;
    bus.dest       = 4'd0;
    bus.alu_result = 32'd0;
    bus.val_rm     = 32'd0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'd0;
  endtask

  // Present one instruction and hold it while freeze is high. The memory model
  // acks on BUSY cycle ack_at (0 = never). Reports edges to retirement, freeze
  // cycles, request cycles, write-back pulses, request-field stability and the
  // first observed request fields.
  task automatic run_op(
    input  logic        r, w, wb,
    input  logic [3:0]  d,
    input  logic [31:0] a, wd, rdata,
    input  int          ack_at,
    output int          n_edges, n_frz, n_busy, n_wb,
    output logic        stable,
    output logic [31:0] req_addr, req_wdata,
    output logic        req_we
  );
    logic f;
    logic done;
    bus.mem_r_en   = r;
    bus.mem_w_en   = w;
    bus.wb_en      = wb;
    bus.dest       = d;
    bus.alu_result = a;
    bus.val_rm     = wd;
    bus.mem_rdata  = rdata;
    bus.mem_ack    = 1'b0;
    #1;
    n_edges = 0; n_frz = 0; n_busy = 0; n_wb = 0;
    stable = 1'b1; req_addr = 32'd0; req_wdata = 32'd0; req_we = 1'b0;
    done = 1'b0;
    while (!done && n_edges < 400) begin
      f = bus.freeze;
      if (f) n_frz++;
      if (bus.mem_req) begin
        n_busy++;
        if (n_busy == 1) begin
          req_addr = bus.mem_addr; req_wdata = bus.mem_wdata; req_we = bus.mem_we;
        end else if (bus.mem_addr !== req_addr || bus.mem_wdata !== req_wdata ||
                     bus.mem_we !== req_we) begin
          stable = 1'b0;
        end
        bus.mem_ack = (n_busy == ack_at);
      end else begin
        bus.mem_ack = 1'b0;
      end
      tick();
      n_edges++;
      if (bus.writeBackEn) n_wb++;
      if (!f) done = 1'b1;
    end
    if (!done) chk("op_retire_bound", 32'd0, 32'd1);
  endtask

  // Advance past the retired instruction with a bubble; a second write-back
  // cycle here would mean the pulse was longer than one cycle.
  task automatic retire(inout int n_wb);
    drive_nop();
    tick();
    if (bus.writeBackEn) n_wb++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive_nop();
    #1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  int          e, fz, bz, wbn;
  logic        st, we;
  logic [31:0] ra, rw, res;
  logic [3:0]  dst;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    drive_nop();
    // Memory op presented during reset must not raise freeze.
    bus.mem_r_en   = 1'b1;
    bus.alu_result = 32'd2000;
    #2;
    chk("rst_freeze", {31'd0, bus.freeze}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_wb_en", {31'd0, bus.writeBackEn}, 32'd0);
    chk("rst_result", bus.Result_WB, 32'd0);
    chk("rst_dest", {28'd0, bus.Dest_wb}, 32'd0);
    chk("rst_addr_err", {31'd0, bus.addr_err}, 32'd0);
    do_reset();

    // ALU op: one edge, no freeze.
    run_op(1'b0, 1'b0, 1'b1, 4'd3, 32'd7, 32'd0, 32'd0, 0, e, fz, bz, wbn, st, ra, rw, we);
    res = bus.Result_WB; dst = bus.Dest_wb;
    retire(wbn);
    chk("alu_edges", e, 1);
    chk("alu_freeze", fz, 0);
    chk("alu_result", res, 32'd7);
    chk("alu_dest", {28'd0, dst}, 32'd3);
    chk("alu_wb_pulses", wbn, 1);

    // Load at 1032, ack on third BUSY cycle.
    run_op(1'b1, 1'b0, 1'b1, 4'd5, 32'd1032, 32'd0, 32'h55, 3, e, fz, bz, wbn, st, ra, rw, we);
    res = bus.Result_WB; dst = bus.Dest_wb;
    retire(wbn);
    chk("ld_mem_addr", ra, 32'd2);
    chk("ld_mem_we", {31'd0, we}, 32'd0);
    chk("ld_freeze", fz, 4);
    chk("ld_busy", bz, 3);
    chk("ld_edges", e, 5);
    chk("ld_result", res, 32'h55);
    chk("ld_dest", {28'd0, dst}, 32'd5);
    chk("ld_wb_pulses", wbn, 1);
    chk("ld_stable", {31'd0, st}, 32'd1);
    chk("ld_addr_err", {31'd0, bus.addr_err}, 32'd0);

    // Store, wb_en=0, ack on second BUSY cycle.
    run_op(1'b0, 1'b1, 1'b0, 4'd6, 32'd1064, 32'hA5, 32'h0, 2, e, fz, bz, wbn, st, ra, rw, we);
    res = bus.Result_WB;
    retire(wbn);
    chk("st_mem_we", {31'd0, we}, 32'd1);
    chk("st_wdata", rw, 32'hA5);
    chk("st_mem_addr", ra, 32'd10);
    chk("st_stable", {31'd0, st}, 32'd1);
    chk("st_freeze", fz, 3);
    chk("st_wb_pulses", wbn, 0);
    chk("st_result", res, 32'd1064);

    // Both enables high: store wins, ack on first BUSY cycle, unaligned address.
    run_op(1'b1, 1'b1, 1'b1, 4'd7, 32'd1103, 32'h77, 32'h1234, 1, e, fz, bz, wbn, st, ra, rw, we);
    res = bus.Result_WB;
    retire(wbn);
    chk("rw_mem_we", {31'd0, we}, 32'd1);
    chk("rw_mem_addr", ra, 32'd19);
    chk("rw_edges", e, 3);
    chk("rw_freeze", fz, 2);
    chk("rw_result", res, 32'd1103);
    chk("rw_wb_pulses", wbn, 1);

    // Load never acked: aborts after 255 BUSY cycles.
    run_op(1'b1, 1'b0, 1'b1, 4'd9, 32'd2048, 32'd0, 32'h0, 0, e, fz, bz, wbn, st, ra, rw, we);
    res = bus.Result_WB;
    retire(wbn);
    chk("to_mem_addr", ra, 32'd256);
    chk("to_busy", bz, 255);
    chk("to_freeze", fz, 256);
    chk("to_result", res, 32'hDEADBEEF);
    chk("to_addr_err", {31'd0, bus.addr_err}, 32'd1);
    chk("to_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("to_wb_pulses", wbn, 1);

    // Sticky error clears only on reset.
    tick();
    chk("err_sticky", {31'd0, bus.addr_err}, 32'd1);
    do_reset();
    chk("err_cleared", {31'd0, bus.addr_err}, 32'd0);

    // Out-of-range load: no request, result 0 after two edges.
    run_op(1'b0, 1'b0, 1'b1, 4'd1, 32'h99, 32'd0, 32'd0, 0, e, fz, bz, wbn, st, ra, rw, we);
    retire(wbn);
    run_op(1'b1, 1'b0, 1'b1, 4'd2, 32'd16, 32'd0, 32'h0, 0, e, fz, bz, wbn, st, ra, rw, we);
    res = bus.Result_WB;
    retire(wbn);
    chk("oor_busy", bz, 0);
    chk("oor_edges", e, 2);
    chk("oor_result", res, 32'd0);
    chk("oor_addr_err", {31'd0, bus.addr_err}, 32'd1);
    chk("oor_wb_pulses", wbn, 1);

    // Reset mid-BUSY: request drops without a clock edge, no write-back later.
    do_reset();
    bus.mem_r_en   = 1'b1;
    bus.wb_en      = 1'b1;
    bus.dest       = 4'd4;
    bus.alu_result = 32'd1040;
    tick();
    chk("rb_mem_req_busy", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rb_mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
    chk("rb_freeze", {31'd0, bus.freeze}, 32'd0);
    drive_nop();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wbn = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.writeBackEn) wbn++;
    end
    chk("rb_wb_pulses", wbn, 0);
    chk("rb_mem_req_after", {31'd0, bus.mem_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
